// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform in units of `step` ticks.
//   Parameter N : nominal PWM resolution; counters/outputs are N+1 bits wide.
//   clk         : single clock
//   rst         : asynchronous active-low reset
//   ena         : measurement enable (low => idle, counters cleared, outputs hold)
//   step        : sample strobe; input sampled and counters advance only here
//   pwm_in      : asynchronous PWM input (2-flop synchronized)
//   period      : last period, rising edge to rising edge, in steps
//   high_time   : last high time in steps
//   valid       : one-cycle pulse whenever period/high_time/stuck flags update
//   stuck_hi/lo : input held constant 1/0 for at least MAX steps
module pwm_capture #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       step,
  input  logic       pwm_in,
  output logic [N:0] period,
  output logic [N:0] high_time,
  output logic       valid,
  output logic       stuck_hi,
  output logic       stuck_lo
);

  localparam logic [N:0] MAX    = '1;
  localparam logic [N:0] ONE    = {{N{1'b0}}, 1'b1};
  localparam logic [N:0] MAX_M1 = MAX - ONE;

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_e;

  state_e     state_q, state_d;
  logic       sync_q, smp_q;
  logic       last_q, last_d;
  logic [N:0] per_q, per_d, hi_q, hi_d;
  logic [N:0] period_q, period_d, high_q, high_d;
  logic       valid_q, valid_d, shi_q, shi_d, slo_q, slo_d;
  logic       rise, fall, edge_seen, timeout;

  function automatic logic [N:0] sat_inc(input logic [N:0] x);
    return (x == MAX) ? MAX : x + ONE;
  endfunction

  assign rise = smp_q & ~last_q;
  assign fall = ~smp_q & last_q;

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    hi_d      = hi_q;
    period_d  = period_q;
    high_d    = high_q;
    shi_d     = shi_q;
    slo_d     = slo_q;
    valid_d   = 1'b0;
    // last tracks smp on every step, even while disabled, so a level that is
    // already high when ena rises is not mistaken for a rising edge
    last_d    = step ? smp_q : last_q;
    edge_seen = 1'b0;
    timeout   = 1'b0;

    if (!ena) begin
      state_d = IDLE;
      per_d   = '0;
      hi_d    = '0;
    end else if (step) begin
      // only edges that move the FSM count; a rise beats a simultaneous timeout
      edge_seen = rise | ((state_q == HIGH) & fall);
      // In IDLE a saturated per_cnt means the timeout already fired; elsewhere
      // per_cnt can sit at MAX only after a fall landed on the last count.
      timeout   = !edge_seen &&
                  ((per_q == MAX_M1) || ((per_q == MAX) && (state_q != IDLE)));

      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            per_d   = ONE;
            hi_d    = ONE;
          end else begin
            per_d = sat_inc(per_q);
          end
        end
        HIGH: begin
          per_d = sat_inc(per_q);
          if (fall) state_d = LOW;
          else      hi_d    = sat_inc(hi_q);
        end
        LOW: begin
          if (rise) begin
            period_d = per_q;
            high_d   = hi_q;
            valid_d  = 1'b1;
            shi_d    = 1'b0;
            slo_d    = 1'b0;
            state_d  = HIGH;
            per_d    = ONE;
            hi_d     = ONE;
          end else begin
            per_d = sat_inc(per_q);
          end
        end
        default: state_d = IDLE;
      endcase

      if (timeout) begin
        state_d  = IDLE;
        per_d    = MAX;
        hi_d     = '0;
        period_d = MAX;
        high_d   = smp_q ? MAX : '0;
        shi_d    = smp_q;
        slo_d    = ~smp_q;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= 1'b0;
      smp_q    <= 1'b0;
      last_q   <= 1'b0;
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      shi_q    <= 1'b0;
      slo_q    <= 1'b0;
    end else begin
      sync_q   <= pwm_in;
      smp_q    <= sync_q;
      last_q   <= last_d;
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      shi_q    <= shi_d;
      slo_q    <= slo_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign stuck_hi  = shi_q;
  assign stuck_lo  = slo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (N=8, MAX=511). Inputs are driven on the
// falling clock edge; results are captured on the falling edge whenever
// valid is high and compared against hand-computed expectations.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b0;
  logic         step = 1'b0;
  logic         pwm_in = 1'b0;
  logic [N:0]   period, high_time;
  logic         valid, stuck_hi, stuck_lo;

  int n_cmp = 0;
  int n_err = 0;
  bit en_v  = 1'b0;

  typedef struct {
    int per;
    int hi;
    bit shi;
    bit slo;
  } res_t;
  res_t q[$];

  typedef struct {
    int div;
    int hi;
    int lo;
    int nper;
    bit glitch;
    int e_per;
    int e_hi;
  } vec_t;
  localparam int NV = 7;
  vec_t vt[NV];

  pwm_capture #(.N(N)) dut (
    .clk(clk), .rst(rst), .ena(ena), .step(step), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .valid(valid),
    .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // capture every published result; valid must never be high two cycles running
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      chk("valid_single_cycle", prev_v, 0);
      q.push_back('{int'(period), int'(high_time), stuck_hi, stuck_lo});
    end
    prev_v <= valid;
  end

  task automatic tick(input bit st, input bit p);
    @(negedge clk);
    step   = st;
    pwm_in = p;
    ena    = en_v;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, pwm_in);
  endtask

  // n steps at level lvl, one step every div cycles; optional 1-cycle high
  // glitch on the step cycle itself, which the synchronizer delays past the
  // sampling point
  task automatic seg(input int div, input int n, input bit lvl, input bit glitch);
    for (int s = 0; s < n; s++)
      for (int c = 0; c < div; c++)
        tick(c == div - 1, lvl | (glitch && (c == div - 1)));
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    en_v = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b0);
  endtask

  task automatic expect_q(input string nm, input int n, input int per, input int hi,
                          input bit shi, input bit slo);
    chk({nm, "_count"}, q.size(), n);
    for (int i = 0; i < q.size(); i++) begin
      chk({nm, "_period"}, q[i].per, per);
      chk({nm, "_high"}, q[i].hi, hi);
      chk({nm, "_stuck_hi"}, q[i].shi, shi);
      chk({nm, "_stuck_lo"}, q[i].slo, slo);
    end
  endtask

  initial begin
    vt[0] = '{div: 1, hi: 64,  lo: 192, nper: 3, glitch: 0, e_per: 256, e_hi: 64};
    vt[1] = '{div: 4, hi: 2,   lo: 1,   nper: 4, glitch: 0, e_per: 3,   e_hi: 2};
    vt[2] = '{div: 4, hi: 2,   lo: 1,   nper: 4, glitch: 1, e_per: 3,   e_hi: 2};
    vt[3] = '{div: 1, hi: 1,   lo: 1,   nper: 3, glitch: 0, e_per: 2,   e_hi: 1};
    vt[4] = '{div: 3, hi: 30,  lo: 70,  nper: 2, glitch: 0, e_per: 100, e_hi: 30};
    vt[5] = '{div: 1, hi: 200, lo: 310, nper: 2, glitch: 0, e_per: 510, e_hi: 200};
    vt[6] = '{div: 2, hi: 5,   lo: 1,   nper: 3, glitch: 0, e_per: 6,   e_hi: 5};

    // reset state
    repeat (3) tick(1'b0, 1'b0);
    chk("reset_period", period, 0);
    chk("reset_high", high_time, 0);
    chk("reset_valid", valid, 0);
    chk("reset_stuck_hi", stuck_hi, 0);
    chk("reset_stuck_lo", stuck_lo, 0);
    rst = 1'b1;

    // table-driven waveforms; a trailing rise closes the last period
    for (int i = 0; i < NV; i++) begin
      do_reset();
      q.delete();
      en_v = 1'b1;
      for (int p = 0; p < vt[i].nper; p++) begin
        seg(vt[i].div, vt[i].hi, 1'b1, 1'b0);
        seg(vt[i].div, vt[i].lo, 1'b0, vt[i].glitch);
      end
      seg(vt[i].div, 4, 1'b1, 1'b0);
      idle(6);
      expect_q($sformatf("vec%0d", i), vt[i].nper, vt[i].e_per, vt[i].e_hi, 1'b0, 1'b0);
    end

    // stuck high: rise lands on step 3, 511 high steps hit MAX
    do_reset();
    q.delete();
    en_v = 1'b1;
    seg(1, 512, 1'b1, 1'b0);
    tick(1'b0, 1'b1);
    chk("stuck_hi_before", stuck_hi, 0);
    seg(1, 1, 1'b1, 1'b0);
    tick(1'b0, 1'b1);
    chk("stuck_hi_set", stuck_hi, 1);
    chk("stuck_hi_period", period, 511);
    chk("stuck_hi_high", high_time, 511);
    seg(1, 100, 1'b1, 1'b0);
    idle(4);
    expect_q("stuck_hi", 1, 511, 511, 1'b1, 1'b0);
    // recover with a 100-step period, 30 high
    q.delete();
    seg(1, 20, 1'b0, 1'b0);
    seg(1, 30, 1'b1, 1'b0);
    seg(1, 70, 1'b0, 1'b0);
    seg(1, 4, 1'b1, 1'b0);
    idle(4);
    expect_q("recover", 1, 100, 30, 1'b0, 1'b0);
    chk("recover_stuck_hi", stuck_hi, 0);

    // stuck low from reset: 511 low steps
    do_reset();
    q.delete();
    en_v = 1'b1;
    seg(1, 510, 1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("stuck_lo_before", stuck_lo, 0);
    seg(1, 1, 1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("stuck_lo_set", stuck_lo, 1);
    chk("stuck_lo_period", period, 511);
    chk("stuck_lo_high", high_time, 0);
    seg(1, 300, 1'b0, 1'b0);
    idle(4);
    expect_q("stuck_lo", 1, 511, 0, 1'b0, 1'b1);

    // enable gating
    do_reset();
    q.delete();
    en_v = 1'b1;
    seg(1, 20, 1'b1, 1'b0);
    seg(1, 20, 1'b0, 1'b0);
    seg(1, 10, 1'b1, 1'b0);
    idle(4);
    expect_q("ena_first", 1, 40, 20, 1'b0, 1'b0);
    q.delete();
    seg(1, 8, 1'b0, 1'b0);
    en_v = 1'b0;
    seg(1, 15, 1'b1, 1'b0);
    seg(1, 15, 1'b0, 1'b0);
    seg(1, 15, 1'b1, 1'b0);
    seg(1, 15, 1'b0, 1'b0);
    chk("ena_hold_period", period, 40);
    chk("ena_hold_high", high_time, 20);
    seg(1, 5, 1'b1, 1'b0);
    chk("ena_gap_valid_count", q.size(), 0);
    en_v = 1'b1;                       // re-enable while input is high
    seg(1, 10, 1'b1, 1'b0);
    seg(1, 25, 1'b0, 1'b0);
    seg(1, 12, 1'b1, 1'b0);            // first counted rise
    seg(1, 13, 1'b0, 1'b0);
    seg(1, 4, 1'b1, 1'b0);             // second rise publishes
    idle(4);
    expect_q("ena_after", 1, 25, 12, 1'b0, 1'b0);

    // asynchronous reset mid-period
    do_reset();
    q.delete();
    en_v = 1'b1;
    seg(1, 20, 1'b1, 1'b0);
    seg(1, 20, 1'b0, 1'b0);
    seg(1, 25, 1'b1, 1'b0);
    idle(2);
    expect_q("rst_pre", 1, 40, 20, 1'b0, 1'b0);
    q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_period", period, 0);
    chk("rst_async_high", high_time, 0);
    chk("rst_async_valid", valid, 0);
    chk("rst_async_stuck", {stuck_hi, stuck_lo}, 0);
    seg(1, 3, 1'b0, 1'b0);
    rst = 1'b1;
    seg(1, 20, 1'b0, 1'b0);
    seg(1, 17, 1'b1, 1'b0);
    seg(1, 23, 1'b0, 1'b0);
    seg(1, 4, 1'b1, 1'b0);
    idle(4);
    expect_q("rst_after", 1, 40, 17, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its period and high time in units of `step` ticks. It is the receive-side counterpart to the team's PWM generator and uses the same `step` prescale convention, so a generator and a capture block sharing one `step` strobe report the generator's duty directly. It is intended for closed-loop checks, such as motor drivers and LED dimmers, and for decoding external PWM inputs such as servo commands and fan tach-style signals.

## Interface
- `N`, default 8. Nominal PWM resolution. The internal counters and the `period`/`high_time` outputs are N+1 bits wide.
- `clk`, in, 1 bit. Single clock for all logic.
- `rst`, in, 1 bit. Reset, asynchronous and active-low; all state clears while it is low.
- `ena`, in, 1 bit. Measurement enable. While low, the block idles.
- `step`, in, 1 bit. Sample strobe. The input is sampled and counters advance only on cycles where `step`=1.
- `pwm_in`, in, 1 bit. Asynchronous PWM input.
- `period`, out, N+1 bits. Last measured period in steps, measured rising edge to rising edge.
- `high_time`, out, N+1 bits. Last measured high time in steps.
- `valid`, out, 1 bit. Pulses for exactly one clk cycle when `period`/`high_time`/stuck flags update.
- `stuck_hi`, out, 1 bit. The input has been constant 1 for at least MAX steps.
- `stuck_lo`, out, 1 bit. The input has been constant 0 for at least MAX steps.

## Operation
- MAX = 2^(N+1)-1. All counters saturate at MAX and never wrap.
- `pwm_in` passes through a 2-flop synchronizer clocked every clk cycle, not gated by `step`. Its reset value is 0.
- `smp` is the synchronized value. `last` holds the `smp` value from the previous step and is updated only on `step` cycles. Its reset value is 0.
- Edge detection happens only on step cycles:
  - rise = `smp` & ~`last`
  - fall = ~`smp` & `last`
- Every `smp` value seen on a step is counted. Pulses shorter than one step may be missed; this is accepted behaviour.
- The state machine has three states: IDLE, HIGH and LOW. The internal counters are `per_cnt` and `hi_cnt`.
- IDLE, on a step:
  - On rise, go to HIGH with `per_cnt`=1 and `hi_cnt`=1.
  - Otherwise, increment `per_cnt` (saturating).
- HIGH, on a step:
  - Increment `per_cnt`.
  - On fall, go to LOW; `hi_cnt` holds.
  - Otherwise, increment `hi_cnt`.
- LOW, on a step:
  - On rise, publish: `period`=`per_cnt`, `high_time`=`hi_cnt`, `valid`=1, and clear both stuck flags.
  - Then restart with `per_cnt`=1, `hi_cnt`=1 and stay in HIGH.
  - Otherwise, increment `per_cnt`.
- Stuck detection applies in any state. When a step would take `per_cnt` to MAX with no edge:
  - If `smp`=1: set `stuck_hi`=1, `period`=MAX, `high_time`=MAX.
  - If `smp`=0: set `stuck_lo`=1, `period`=MAX, `high_time`=0.
  - Pulse `valid` once, then go to IDLE.
  - Stay in IDLE with `per_cnt` saturated and do not assert `valid` again until the next rise.
- Simultaneous events:
  - A rise on the same step that `per_cnt` hits MAX counts as an edge; the timeout is ignored.
  - `step` pulses while `ena`=0 have no effect.
- `ena` low:
  - State goes to IDLE, `per_cnt`/`hi_cnt` clear, and `valid`=0.
  - `period`, `high_time` and the stuck flags hold their last values.
  - `last` keeps tracking `smp` on steps, so a level that is already high when `ena` rises is not treated as a rise.
- The first period after reset or after `ena` rises is never published, because measurement waits for a rising edge.

## Timing
- Reset values: `period`=0, `high_time`=0, `valid`=0, `stuck_hi`=0, `stuck_lo`=0, state IDLE.
- Asserting `rst` mid-measurement discards the measurement in progress; no `valid` is produced.
- Input latency: a change on `pwm_in` appears in `smp` 2 clk cycles later and is acted on at the next step.
- All outputs are registered. They update on the clk edge that ends the qualifying step cycle and are visible on the following cycle.
- `valid` is high for exactly 1 clk cycle and never on two consecutive cycles.
- Throughput: one result per input period. The minimum measurable period is 2 steps (1 high, 1 low).

## Test plan
- **Basic duty measurement.** Setup: N=8, `step` every cycle, input 256-step period with 64 steps high, run for 3 periods. Required: from the second rising edge on, `valid` pulses once per period with `period`=256 and `high_time`=64.
- **Minimum period and fractional step.** Setup: `step` every 4 cycles, input 2 steps high / 1 step low. Required: `period`=3, `high_time`=2. Then apply a 1-cycle glitch between steps. Required: the glitch is not counted.
- **Stuck high.** Setup: hold `pwm_in`=1 after a rise. Required: after 511 steps, `stuck_hi`=1, `period`=511, `high_time`=511, and a single `valid`. Then resume a 100-step period with 30 steps high. Required: on the first full period, `stuck_hi` clears, `period`=100, `high_time`=30.
- **Stuck low from reset.** Setup: hold `pwm_in`=0 from reset. Required: `stuck_lo`=1 and `high_time`=0 after 511 steps; no further `valid`.
- **Enable gating.** Setup: deassert `ena` mid-period, then reassert it while the input is high. Required: no `valid` during the gap, outputs hold, and the next result arrives only after two subsequent rising edges.
- **Reset mid-operation.** Setup: assert `rst` (low) mid-period. Required: all outputs read 0 immediately (asynchronously). After release, no `valid` is produced before two rising edges.
